// File: rtl/ct_had_pcfifo_ctrl.sv
// ct_had_pcfifo_ctrl
//   Control stage in front of the HAD PC FIFO: write gating with a post-resume
//   mask, debugger read sequencing (pop, capture, ack) and an optional
//   occupancy counter.
//   Optional feature macro: CT_HAD_PCFIFO_CNT_EN (builds the occupancy counter;
//   when undefined pcfifo_cnt is tied to 0 and no counter flops exist).
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for a debugger read request
//   ST_RD    | pop one FIFO entry (ren high for this cycle only)
//   ST_CAP   | FIFO output valid, captured into rd_data at end of cycle
//   ST_ACK   | read complete, ack high for one cycle
//   ST_ERR   | request outside debug mode, ack with zero data
module ct_had_pcfifo_ctrl #(
   parameter int DEPTH       = 16,
   parameter int CNT_WIDTH   = 5,
   parameter int RESUME_MASK = 2,
   parameter int DATAW       = 64
) (
   input  logic                 cpuclk,
   input  logic                 cpurst_b,
   input  logic                 had_trace_en,
   input  logic                 had_dbg_mode,
   input  logic                 rtu_had_xx_pcfifo_inst0_chgflow,
   input  logic                 rtu_had_xx_pcfifo_inst1_chgflow,
   input  logic                 rtu_had_xx_pcfifo_inst2_chgflow,
   input  logic                 regs_pcfifo_rd_req,
   input  logic [DATAW-1:0]     pcfifo_regs_data,
   output logic                 ctrl_pcfifo_wen,
   output logic                 ctrl_pcfifo_ren,
   output logic                 pcfifo_rd_ack,
   output logic [DATAW-1:0]     pcfifo_rd_data,
   output logic [CNT_WIDTH-1:0] pcfifo_cnt,
   output logic                 pcfifo_rd_busy
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_ACK  = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             dbg_mode_q;
   logic [3:0]       mask_cnt_q, mask_cnt_d;
   logic [DATAW-1:0] rd_data_q, rd_data_d;
   logic             ren, ack;

   // The mask loads on the edge that sees the debug-mode fall, so it gates
   // the RESUME_MASK cycles that follow that edge.
   always_comb begin
      mask_cnt_d = mask_cnt_q;
      if (had_dbg_mode) begin
         mask_cnt_d = 4'd0;
      end else if (dbg_mode_q) begin
         mask_cnt_d = 4'(RESUME_MASK);
      end else if (mask_cnt_q != 4'd0) begin
         mask_cnt_d = mask_cnt_q - 4'd1;
      end
   end

   // Debug-mode history and resume mask registers.
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         dbg_mode_q <= 1'b0;
         mask_cnt_q <= 4'd0;
      end else begin
         dbg_mode_q <= had_dbg_mode;
         mask_cnt_q <= mask_cnt_d;
      end
   end

   assign ctrl_pcfifo_wen = had_trace_en & ~had_dbg_mode & (mask_cnt_q == 4'd0);

   // Read FSM next state, strobes and read-data selection.
   always_comb begin
      state_d   = state_q;
      rd_data_d = rd_data_q;
      ren       = 1'b0;
      ack       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (regs_pcfifo_rd_req) begin
               if (had_dbg_mode) begin
                  state_d = ST_RD;
               end else begin
                  state_d   = ST_ERR;
                  rd_data_d = '0;
               end
            end
         end
         ST_RD: begin
            ren     = 1'b1;
            state_d = ST_CAP;
         end
         ST_CAP: begin
            rd_data_d = pcfifo_regs_data;
            state_d   = ST_ACK;
         end
         ST_ACK: begin
            ack     = 1'b1;
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            ack     = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Read FSM state and captured data registers.
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q   <= ST_IDLE;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign ctrl_pcfifo_ren = ren;
   assign pcfifo_rd_ack   = ack;
   assign pcfifo_rd_data  = rd_data_q;
   assign pcfifo_rd_busy  = (state_q != ST_IDLE);

`ifdef CT_HAD_PCFIFO_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH:0]   cnt_sum;
   logic [1:0]           inc;
   logic                 dec;

   // Saturating occupancy: sum is one bit wider so it cannot wrap before clamping.
   always_comb begin
      inc = 2'd0;
      if (ctrl_pcfifo_wen) begin
         inc = {1'b0, rtu_had_xx_pcfifo_inst0_chgflow}
             + {1'b0, rtu_had_xx_pcfifo_inst1_chgflow}
             + {1'b0, rtu_had_xx_pcfifo_inst2_chgflow};
      end
      dec     = ren & (cnt_q != '0);
      cnt_sum = {1'b0, cnt_q} + (CNT_WIDTH+1)'(inc) - (CNT_WIDTH+1)'(dec);
      if (cnt_sum > (CNT_WIDTH+1)'(DEPTH)) begin
         cnt_d = CNT_WIDTH'(DEPTH);
      end else begin
         cnt_d = cnt_sum[CNT_WIDTH-1:0];
      end
   end

   // Occupancy register.
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pcfifo_cnt = cnt_q;
`else
   logic cnt_unused;
   assign cnt_unused = rtu_had_xx_pcfifo_inst0_chgflow ^ rtu_had_xx_pcfifo_inst1_chgflow
                     ^ rtu_had_xx_pcfifo_inst2_chgflow;
   assign pcfifo_cnt = '0;
`endif

endmodule

// File: tb/tb_ct_had_pcfifo_ctrl.sv
// Directed bench for ct_had_pcfifo_ctrl. Expected occupancy values follow the
// CT_HAD_PCFIFO_CNT_EN build setting (0 when the counter is not built).
module tb_ct_had_pcfifo_ctrl;

`ifdef CT_HAD_PCFIFO_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic        cpuclk;
   logic        cpurst_b;
   logic        had_trace_en;
   logic        had_dbg_mode;
   logic [2:0]  chg;
   logic        rd_req;
   logic [63:0] fifo_data;
   logic        wen, ren, ack, busy;
   logic [63:0] rd_data;
   logic [4:0]  cnt;

   int n_checks = 0;
   int n_errors = 0;

   ct_had_pcfifo_ctrl dut (
      .cpuclk                          (cpuclk),
      .cpurst_b                        (cpurst_b),
      .had_trace_en                    (had_trace_en),
      .had_dbg_mode                    (had_dbg_mode),
      .rtu_had_xx_pcfifo_inst0_chgflow (chg[0]),
      .rtu_had_xx_pcfifo_inst1_chgflow (chg[1]),
      .rtu_had_xx_pcfifo_inst2_chgflow (chg[2]),
      .regs_pcfifo_rd_req              (rd_req),
      .pcfifo_regs_data                (fifo_data),
      .ctrl_pcfifo_wen                 (wen),
      .ctrl_pcfifo_ren                 (ren),
      .pcfifo_rd_ack                   (ack),
      .pcfifo_rd_data                  (rd_data),
      .pcfifo_cnt                      (cnt),
      .pcfifo_rd_busy                  (busy)
   );

   initial cpuclk = 1'b0;
   always #5 cpuclk = ~cpuclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_cnt(input int v);
      return CNT_ON ? 64'(v) : 64'd0;
   endfunction

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge cpuclk);
      #1;
   endtask

   initial begin
      cpurst_b     = 1'b0;
      had_trace_en = 1'b0;
      had_dbg_mode = 1'b0;
      chg          = 3'b000;
      rd_req       = 1'b0;
      fifo_data    = 64'h0;
      #12;
      check("rst_wen",  64'(wen),  64'd0);
      check("rst_ren",  64'(ren),  64'd0);
      check("rst_ack",  64'(ack),  64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_data", rd_data,   64'd0);
      check("rst_cnt",  64'(cnt),  64'd0);
      step();
      cpurst_b = 1'b1;
      step();

      // 1: three writes in one cycle
      had_trace_en = 1'b1;
      chg          = 3'b111;
      #1;
      check("t1_wen", 64'(wen), 64'd1);
      step();
      chg = 3'b000;
      check("t1_cnt", 64'(cnt), exp_cnt(3));

      // bring count to 15
      chg = 3'b111;
      for (int i = 0; i < 4; i++) step();
      chg = 3'b000;
      #1;
      check("fill_cnt", 64'(cnt), exp_cnt(15));

      // 2: +2 and a pop in the same cycle (first cycle after debug falls)
      had_dbg_mode = 1'b1;
      rd_req       = 1'b1;
      step();
      rd_req       = 1'b0;
      had_dbg_mode = 1'b0;
      chg          = 3'b011;
      #1;
      check("t2_ren", 64'(ren), 64'd1);
      check("t2_wen", 64'(wen), 64'd1);
      step();
      chg = 3'b000;
      check("t2_cnt",      64'(cnt), exp_cnt(16));
      check("t2_mask1",    64'(wen), 64'd0);
      step();
      check("t2_mask2",    64'(wen), 64'd0);
      check("t2_ack",      64'(ack), 64'd1);
      step();
      check("t2_unmask",   64'(wen), 64'd1);
      chg = 3'b111;
      step();
      chg = 3'b000;
      check("t2_sat",      64'(cnt), exp_cnt(16));

      // 3: debug read with a dropped second request
      had_trace_en = 1'b0;
      had_dbg_mode = 1'b1;
      step();
      rd_req = 1'b1;
      #1;
      check("t3_idle_busy", 64'(busy), 64'd0);
      check("t3_n_ren",     64'(ren),  64'd0);
      step();
      check("t3_n1_ren",  64'(ren),  64'd1);
      check("t3_n1_busy", 64'(busy), 64'd1);
      step();
      rd_req    = 1'b0;
      fifo_data = 64'h0000_0000_8000_1234;
      check("t3_n2_ren", 64'(ren), 64'd0);
      check("t3_n2_ack", 64'(ack), 64'd0);
      check("t3_n2_cnt", 64'(cnt), exp_cnt(15));
      step();
      fifo_data = 64'hdead_beef_dead_beef;
      check("t3_n3_ack",  64'(ack), 64'd1);
      check("t3_n3_data", rd_data,  64'h0000_0000_8000_1234);
      check("t3_n3_ren",  64'(ren), 64'd0);
      step();
      check("t3_n4_ack",  64'(ack),  64'd0);
      check("t3_n4_busy", 64'(busy), 64'd0);
      check("t3_n4_ren",  64'(ren),  64'd0);
      check("t3_n4_data", rd_data,   64'h0000_0000_8000_1234);

      // 4: request outside debug mode
      had_dbg_mode = 1'b0;
      step();
      step();
      step();
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      check("t4_ack",  64'(ack),  64'd1);
      check("t4_data", rd_data,   64'd0);
      check("t4_ren",  64'(ren),  64'd0);
      check("t4_busy", 64'(busy), 64'd1);
      step();
      check("t4_ack_end", 64'(ack),  64'd0);
      check("t4_idle",    64'(busy), 64'd0);
      check("t4_cnt",     64'(cnt),  exp_cnt(15));

      // 5: resume mask
      had_trace_en = 1'b1;
      had_dbg_mode = 1'b1;
      step();
      step();
      had_dbg_mode = 1'b0;
      step();
      chg = 3'b111;
      check("t5_mask1", 64'(wen), 64'd0);
      step();
      check("t5_mask2", 64'(wen), 64'd0);
      step();
      chg = 3'b000;
      check("t5_open",  64'(wen), 64'd1);
      check("t5_cnt",   64'(cnt), exp_cnt(15));
      chg = 3'b001;
      step();
      chg = 3'b000;
      check("t5_cnt_inc", 64'(cnt), exp_cnt(16));

      // 6: reset while in CAP, then a read on an empty FIFO
      had_dbg_mode = 1'b1;
      rd_req       = 1'b1;
      step();
      rd_req = 1'b0;
      step();
      check("t6_cap_busy", 64'(busy), 64'd1);
      cpurst_b = 1'b0;
      #1;
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_ack",  64'(ack),  64'd0);
      check("t6_rst_ren",  64'(ren),  64'd0);
      check("t6_rst_data", rd_data,   64'd0);
      check("t6_rst_cnt",  64'(cnt),  64'd0);
      step();
      cpurst_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t6_no_ack", 64'(ack), 64'd0);
      end
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      check("t6_empty_ren", 64'(ren), 64'd1);
      step();
      check("t6_empty_cnt", 64'(cnt), 64'd0);
      step();
      step();
      check("t6_idle", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
